bcd_mod_counter: RTL and testbench

Parametrised two-digit BCD modulo counter, the successor to the fixed mod-24 hour counter in the alarm-clock datapath. It supports up/down counting, validated parallel load (time/alarm setting), a registered carry/borrow pulse for cascading, and a registered 12-hour display image with a PM flag. One instance per clock field: hours (MODULUS=24), minutes and seconds (MODULUS=60).

---
 rtl/bcd_mod_counter_if.sv | 27 ++
 rtl/bcd_mod_counter.sv | 148 ++++++++++++++
 tb/tb_bcd_mod_counter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_mod_counter_if.sv
// Control and data bundle for one bcd_mod_counter field (hours, minutes or seconds).
// The master side drives the count/load controls, the slave side is the counter itself.
interface bcd_mod_counter_if;
    logic       EN;
    logic       UP;
    logic       LD;
    logic [3:0] DinH;
    logic [3:0] DinL;
    logic       MODE12;
    logic [3:0] CntH;
    logic [3:0] CntL;
    logic [3:0] DispH;
    logic [3:0] DispL;
    logic       PM;
    logic       CO;
    logic       LdErr;

    modport master (
        output EN, UP, LD, DinH, DinL, MODE12,
        input  CntH, CntL, DispH, DispL, PM, CO, LdErr
    );

    modport slave (
        input  EN, UP, LD, DinH, DinL, MODE12,
        output CntH, CntL, DispH, DispL, PM, CO, LdErr
    );
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with up/down count, validated load, carry/borrow pulse
// and a registered display image (optional 12-hour form for the hours field).
module bcd_mod_counter #(
    parameter int MODULUS = 24
) (
    input  logic               CP,
    input  logic               CR,
    bcd_mod_counter_if.slave   bus
);

    if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
        $error("bcd_mod_counter: MODULUS must be in 2..100");
    end

    localparam logic [7:0] MOD_V  = 8'(MODULUS);
    localparam logic [7:0] MOD_M1 = 8'(MODULUS - 1);
    localparam logic [3:0] MAX_H  = 4'((MODULUS - 1) / 10);
    localparam logic [3:0] MAX_L  = 4'((MODULUS - 1) % 10);
    localparam bit         IS_HOUR = (MODULUS == 24);

    logic [3:0] r_cnt_h;
    logic [3:0] r_cnt_l;
    logic [3:0] r_disp_h;
    logic [3:0] r_disp_l;
    logic       r_pm;
    logic       r_co;
    logic       r_ld_err;

    logic [7:0] w_v;
    logic [7:0] w_din_v;
    logic       w_cnt_ok;
    logic       w_din_ok;

    logic [3:0] w_cnt_h_next;
    logic [3:0] w_cnt_l_next;
    logic       w_co_next;
    logic       w_ld_err_next;

    logic       w_hour12;
    logic [7:0] w_h12;
    logic [3:0] w_disp_h_next;
    logic [3:0] w_disp_l_next;
    logic       w_pm_next;

    // Binary value is used only for range checks and the display image, never to step the count.
    assign w_v      = 8'd10 * {4'd0, r_cnt_h} + {4'd0, r_cnt_l};
    assign w_din_v  = 8'd10 * {4'd0, bus.DinH} + {4'd0, bus.DinL};
    assign w_cnt_ok = (r_cnt_h <= 4'd9) && (r_cnt_l <= 4'd9) && (w_v < MOD_V);
    assign w_din_ok = (bus.DinH <= 4'd9) && (bus.DinL <= 4'd9) && (w_din_v < MOD_V);

    always_comb begin
        w_cnt_h_next  = r_cnt_h;
        w_cnt_l_next  = r_cnt_l;
        w_co_next     = 1'b0;
        w_ld_err_next = r_ld_err;
        if (bus.LD) begin
            if (w_din_ok) begin
                w_cnt_h_next  = bus.DinH;
                w_cnt_l_next  = bus.DinL;
                w_ld_err_next = 1'b0;
            end else begin
                w_ld_err_next = 1'b1;
            end
        end else if (bus.EN) begin
            if (!w_cnt_ok) begin
                // Corrupted state recovers to zero without signalling a wrap.
                w_cnt_h_next = 4'd0;
                w_cnt_l_next = 4'd0;
            end else if (bus.UP) begin
                if (w_v == MOD_M1) begin
                    w_cnt_h_next = 4'd0;
                    w_cnt_l_next = 4'd0;
                    w_co_next    = 1'b1;
                end else if (r_cnt_l == 4'd9) begin
                    w_cnt_h_next = r_cnt_h + 4'd1;
                    w_cnt_l_next = 4'd0;
                end else begin
                    w_cnt_l_next = r_cnt_l + 4'd1;
                end
            end else begin
                if (w_v == 8'd0) begin
                    w_cnt_h_next = MAX_H;
                    w_cnt_l_next = MAX_L;
                    w_co_next    = 1'b1;
                end else if (r_cnt_l == 4'd0) begin
                    w_cnt_h_next = r_cnt_h - 4'd1;
                    w_cnt_l_next = 4'd9;
                end else begin
                    w_cnt_l_next = r_cnt_l - 4'd1;
                end
            end
        end
    end

    assign w_hour12 = IS_HOUR && bus.MODE12;

    always_comb begin
        w_h12         = w_v;
        w_disp_h_next = r_cnt_h;
        w_disp_l_next = r_cnt_l;
        w_pm_next     = 1'b0;
        if (w_hour12) begin
            if (w_v == 8'd0) begin
                w_h12 = 8'd12;
            end else if (w_v > 8'd12) begin
                w_h12 = w_v - 8'd12;
            end
            w_pm_next = (w_v >= 8'd12);
            // Image is 1..12, so the tens digit is 0 or 1.
            if (w_h12 >= 8'd10) begin
                w_disp_h_next = 4'd1;
                w_disp_l_next = 4'(w_h12 - 8'd10);
            end else begin
                w_disp_h_next = 4'd0;
                w_disp_l_next = 4'(w_h12);
            end
        end
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            r_cnt_h  <= 4'd0;
            r_cnt_l  <= 4'd0;
            r_disp_h <= 4'd0;
            r_disp_l <= 4'd0;
            r_pm     <= 1'b0;
            r_co     <= 1'b0;
            r_ld_err <= 1'b0;
        end else begin
            r_cnt_h  <= w_cnt_h_next;
            r_cnt_l  <= w_cnt_l_next;
            r_co     <= w_co_next;
            r_ld_err <= w_ld_err_next;
            r_disp_h <= w_disp_h_next;
            r_disp_l <= w_disp_l_next;
            r_pm     <= w_pm_next;
        end
    end

    assign bus.CntH  = r_cnt_h;
    assign bus.CntL  = r_cnt_l;
    assign bus.DispH = r_disp_h;
    assign bus.DispL = r_disp_l;
    assign bus.PM    = r_pm;
    assign bus.CO    = r_co;
    assign bus.LdErr = r_ld_err;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Scoreboard bench for bcd_mod_counter: an hours (24) and a minutes (60) instance share stimulus,
// each with its own integer-valued reference model and expected-response queue.
module tb_bcd_mod_counter;

    typedef struct packed {
        logic [3:0] ch;
        logic [3:0] cl;
        logic [3:0] dh;
        logic [3:0] dl;
        logic       pm;
        logic       co;
        logic       err;
    } exp_t;

    logic clk;
    logic cr;

    bcd_mod_counter_if bus24();
    bcd_mod_counter_if bus60();

    bcd_mod_counter #(.MODULUS(24)) u_hours (.CP(clk), .CR(cr), .bus(bus24));
    bcd_mod_counter #(.MODULUS(60)) u_mins  (.CP(clk), .CR(cr), .bus(bus60));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   mods [2] = '{24, 60};
    int   m_v  [2];
    bit   m_err[2];
    int   m_dv [2];
    bit   m_pm [2];
    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;
    int   txn   = 0;

    // Reference model: value kept as a plain integer, stepped with modular arithmetic.
    function automatic exp_t model_step(input int k, input bit c_r, input bit en, input bit up,
                                        input bit ld, input int dh, input int dl, input bit m12);
        exp_t e;
        int   md;
        int   img;
        bit   co;
        md = mods[k];
        co = 1'b0;
        if (c_r) begin
            m_v[k]   = 0;
            m_err[k] = 1'b0;
            m_dv[k]  = 0;
            m_pm[k]  = 1'b0;
        end else begin
            if (md == 24 && m12) begin
                img      = (m_v[k] % 12 == 0) ? 12 : m_v[k] % 12;
                m_dv[k]  = img;
                m_pm[k]  = (m_v[k] >= 12);
            end else begin
                m_dv[k]  = m_v[k];
                m_pm[k]  = 1'b0;
            end
            if (ld) begin
                if (dh <= 9 && dl <= 9 && (10 * dh + dl) < md) begin
                    m_v[k]   = 10 * dh + dl;
                    m_err[k] = 1'b0;
                end else begin
                    m_err[k] = 1'b1;
                end
            end else if (en) begin
                if (up) begin
                    co     = (m_v[k] == md - 1);
                    m_v[k] = (m_v[k] + 1) % md;
                end else begin
                    co     = (m_v[k] == 0);
                    m_v[k] = (m_v[k] + md - 1) % md;
                end
            end
        end
        e.ch  = 4'(m_v[k] / 10);
        e.cl  = 4'(m_v[k] % 10);
        e.dh  = 4'(m_dv[k] / 10);
        e.dl  = 4'(m_dv[k] % 10);
        e.pm  = m_pm[k];
        e.co  = co;
        e.err = m_err[k];
        return e;
    endfunction

    task automatic step(input bit c_r, input bit en, input bit up, input bit ld,
                        input int dh, input int dl, input bit m12);
        @(negedge clk);
        cr           = c_r;
        bus24.EN     = en;   bus60.EN     = en;
        bus24.UP     = up;   bus60.UP     = up;
        bus24.LD     = ld;   bus60.LD     = ld;
        bus24.DinH   = 4'(dh); bus60.DinH = 4'(dh);
        bus24.DinL   = 4'(dl); bus60.DinL = 4'(dl);
        bus24.MODE12 = m12;  bus60.MODE12 = m12;
        q0.push_back(model_step(0, c_r, en, up, ld, dh, dl, m12));
        q1.push_back(model_step(1, c_r, en, up, ld, dh, dl, m12));
    endtask

    function automatic exp_t actual(input int k);
        exp_t a;
        if (k == 0) a = {bus24.CntH, bus24.CntL, bus24.DispH, bus24.DispL, bus24.PM, bus24.CO, bus24.LdErr};
        else        a = {bus60.CntH, bus60.CntL, bus60.DispH, bus60.DispL, bus60.PM, bus60.CO, bus60.LdErr};
        return a;
    endfunction

    task automatic check(input int k, input exp_t e);
        exp_t a;
        a = actual(k);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL mod%0d txn=%0d got cnt=%h%h disp=%h%h pm=%b co=%b err=%b want cnt=%h%h disp=%h%h pm=%b co=%b err=%b",
                     mods[k], txn, a.ch, a.cl, a.dh, a.dl, a.pm, a.co, a.err,
                     e.ch, e.cl, e.dh, e.dl, e.pm, e.co, e.err);
        end else begin
            $display("txn %0d mod%0d cnt=%h%h disp=%h%h pm=%b co=%b err=%b ok",
                     txn, mods[k], a.ch, a.cl, a.dh, a.dl, a.pm, a.co, a.err);
        end
    endtask

    // Monitor: every clock the DUTs present a new registered response.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) check(0, q0.pop_front());
            if (q1.size() > 0) check(1, q1.pop_front());
            txn++;
        end
    end

    initial begin
        int r;
        int dh;
        int dl;
        cr = 1'b1;
        bus24.EN = 1'b0; bus24.UP = 1'b0; bus24.LD = 1'b0; bus24.DinH = 4'd0; bus24.DinL = 4'd0; bus24.MODE12 = 1'b0;
        bus60.EN = 1'b0; bus60.UP = 1'b0; bus60.LD = 1'b0; bus60.DinH = 4'd0; bus60.DinL = 4'd0; bus60.MODE12 = 1'b0;

        // Reset overrides simultaneous load and count.
        step(1, 1, 1, 1, 1, 5, 0);
        step(1, 1, 1, 1, 1, 5, 0);
        // Load 22 and count up through the wrap.
        step(0, 0, 1, 1, 2, 2, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        // Borrow from 00, then tens borrow from 10.
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        // Illegal digit, out-of-range value, then a legal load clearing the error.
        step(0, 0, 1, 1, 1, 10, 0);
        step(0, 0, 1, 1, 2, 4, 0);
        step(0, 0, 1, 1, 2, 3, 0);
        // 12-hour display image at the interesting hours.
        step(0, 0, 1, 1, 0, 0, 1);
        step(0, 0, 1, 1, 1, 1, 1);
        step(0, 0, 1, 1, 1, 2, 1);
        step(0, 0, 1, 1, 1, 3, 1);
        step(0, 0, 1, 1, 2, 3, 1);
        step(0, 0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0);
        // Minutes wrap at 59; load beats enable on the same edge.
        step(0, 0, 1, 1, 5, 9, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 3, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);

        // Randomised phase: mostly counting, occasional loads (some illegal) and resets.
        for (int i = 0; i < 250; i++) begin
            r  = int'($urandom_range(0, 99));
            dh = (($urandom_range(0, 7)) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 6));
            dl = (($urandom_range(0, 7)) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            step(r < 3, ($urandom_range(0, 3)) != 0, ($urandom_range(0, 1)) != 0,
                 r >= 3 && r < 15, dh, dl, ($urandom_range(0, 1)) != 0);
        end

        @(negedge clk);
        @(negedge clk);
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL drain got q0=%0d q1=%0d want 0 0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
